// File: rtl/rx_serial_pkg.sv
// rx_serial_pkg: shared FSM state codes and default bit timing for the 8N1 receiver.
package rx_serial_pkg;
  localparam int CLKS_PER_BIT_DEF = 434;
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    DATA  = 4'd2,
    STOP  = 4'd3,
    DONE  = 4'd4,
    ERRO  = 4'd5
  } estado_t;
endpackage

// File: rtl/contador_baud.sv
// contador_baud: baud counter with clear/enable; ticks at half or full bit period.
module contador_baud
  import rx_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic half,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] FULL_END = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_END = W'(CLKS_PER_BIT / 2 - 1);
  logic [W-1:0] cnt;
  assign tick = enable && cnt == (half ? HALF_END : FULL_END);
  // Wrapping on tick restarts the next bit period with no extra clear cycle.
  always_ff @(posedge clock)
    cnt <= (!reset || clear || tick) ? '0 : enable ? cnt + W'(1) : cnt;
endmodule

// File: rtl/rx_serial_8n1.sv
// rx_serial_8n1: 8N1 UART receiver sampling mid-bit, with debug taps.
module rx_serial_8n1
  import rx_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  output logic       pronto,
  output logic [7:0] dados_ascii,
  output logic       db_clock,
  output logic       db_tick,
  output logic [7:0] db_dados,
  output logic [3:0] db_estado
);
  estado_t state, state_n;
  logic [1:0] sync;
  logic [2:0] idx, idx_n;
  logic [7:0] sr, sr_n, dados_n;
  logic rx_s, tick, active;
  assign rx_s = sync[1];
  assign active = state == START || state == DATA || state == STOP;
  contador_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock(clock),
    .reset(reset),
    .clear(!active),
    .enable(active),
    .half(state == START),
    .tick(tick)
  );
  always_ff @(posedge clock) sync <= !reset ? 2'b11 : {sync[0], RX};
  always_ff @(posedge clock)
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      sr          <= '0;
      dados_ascii <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      sr          <= sr_n;
      dados_ascii <= dados_n;
    end
  // Byte is latched on the good stop sample so it is valid alongside pronto.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    sr_n    = sr;
    dados_n = dados_ascii;
    case (state)
      IDLE:  if (!rx_s) state_n = START;
      START: if (tick) begin
        state_n = rx_s ? IDLE : DATA;
        idx_n   = '0;
      end
      DATA:  if (tick) begin
        sr_n    = {rx_s, sr[7:1]};
        idx_n   = idx + 3'd1;
        state_n = idx == 3'd7 ? STOP : DATA;
      end
      STOP:  if (tick) begin
        state_n = rx_s ? DONE : ERRO;
        dados_n = rx_s ? sr : dados_ascii;
      end
      DONE:  state_n = IDLE;
      ERRO:  if (rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign pronto    = state == DONE;
  assign db_clock  = clock;
  assign db_tick   = tick;
  assign db_dados  = sr;
  assign db_estado = state;
endmodule

// File: tb/tb_rx_serial_8n1.sv
// tb_rx_serial_8n1: directed frames checking bytes, pronto, tick timing and error paths.
module tb_rx_serial_8n1;
  localparam int CLKS = 434;
  localparam int HALF = 217;
  logic clock = 0, reset = 0, RX = 1;
  logic pronto, db_clock, db_tick;
  logic [7:0] dados_ascii, db_dados;
  logic [3:0] db_estado;
  int cyc = 0, checks = 0, errors = 0, c0 = 0, ti = 0;
  logic [7:0] got[$];
  logic pronto_q = 0;
  rx_serial_8n1 dut (
    .clock(clock), .reset(reset), .RX(RX), .pronto(pronto),
    .dados_ascii(dados_ascii), .db_clock(db_clock), .db_tick(db_tick),
    .db_dados(db_dados), .db_estado(db_estado)
  );
  always #10 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (pronto) begin
      got.push_back(dados_ascii);
      checks++;
      assert (pronto_q === 1'b0) else begin
        errors++;
        $error("FAIL pronto_width: got 2+ cycles expected 1");
      end
    end
    pronto_q = pronto;
  end
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // Tick j of a frame is expected at RX edge + 2 sync clocks + HALF + j*CLKS.
  task automatic watch(input int n);
    int dlt;
    repeat (n) begin
      @(negedge clock);
      if (db_tick) begin
        dlt = cyc - c0 - (HALF + 2 + ti * CLKS);
        checks++;
        assert (dlt >= -1 && dlt <= 1) else begin
          errors++;
          $error("FAIL tick_pos[%0d]: got offset %0d expected %0d", ti, cyc - c0, HALF + 2 + ti * CLKS);
        end
        ti++;
      end
    end
  endtask
  task automatic send(input logic [7:0] d, input logic stp, input int nstop);
    logic [9:0] f;
    f  = {stp, d, 1'b0};
    ti = 0;
    c0 = cyc;
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      watch(CLKS);
    end
    for (int i = 1; i < nstop; i++) begin
      RX = 1'b1;
      watch(CLKS);
    end
    chk("tick_count", ti, 10);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_pronto"}, 32'(pronto), 0);
    chk({tag, "_dados"}, 32'(dados_ascii), 0);
    chk({tag, "_tick"}, 32'(db_tick), 0);
    chk({tag, "_db_dados"}, 32'(db_dados), 0);
    chk({tag, "_estado"}, 32'(db_estado), 0);
  endtask
  initial begin
    logic [9:0] f;
    repeat (5) @(negedge clock);
    chk_zero("reset");
    chk("db_clock", 32'(db_clock), 0);
    reset = 1;
    repeat (CLKS) @(negedge clock);
    send(8'h35, 1'b1, 2);
    send(8'h0F, 1'b1, 2);
    chk("t1_count", got.size(), 2);
    chk("t1_byte0", 32'(got[0]), 32'h35);
    chk("t1_byte1", 32'(got[1]), 32'h0F);
    chk("t1_hold", 32'(dados_ascii), 32'h0F);
    send(8'hB5, 1'b1, 2);
    send(8'hAA, 1'b1, 2);
    repeat (2 * CLKS) @(negedge clock);
    send(8'hD5, 1'b1, 2);
    send(8'h21, 1'b1, 2);
    repeat (2 * CLKS) @(negedge clock);
    chk("t2_count", got.size(), 6);
    chk("t2_byte2", 32'(got[2]), 32'hB5);
    chk("t2_byte3", 32'(got[3]), 32'hAA);
    chk("t2_byte4", 32'(got[4]), 32'hD5);
    chk("t2_byte5", 32'(got[5]), 32'h21);
    chk("t2_hold", 32'(dados_ascii), 32'h21);
    RX = 1'b0;
    repeat (100) @(negedge clock);
    RX = 1'b1;
    repeat (CLKS) @(negedge clock);
    chk("t3_count", got.size(), 6);
    chk("t3_estado", 32'(db_estado), 0);
    chk("t3_hold", 32'(dados_ascii), 32'h21);
    send(8'h55, 1'b0, 1);
    chk("t4_estado_erro", 32'(db_estado), 5);
    chk("t4_count", got.size(), 6);
    RX = 1'b1;
    repeat (5) @(negedge clock);
    chk("t4_estado_idle", 32'(db_estado), 0);
    chk("t4_hold", 32'(dados_ascii), 32'h21);
    repeat (CLKS) @(negedge clock);
    f = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      RX = f[i];
      repeat (CLKS) @(negedge clock);
    end
    RX = f[5];
    repeat (HALF) @(negedge clock);
    chk("t5_midframe", 32'(db_estado), 2);
    reset = 0;
    repeat (3) @(negedge clock);
    chk_zero("t5_reset");
    reset = 1;
    RX = 1'b1;
    repeat (2 * CLKS) @(negedge clock);
    chk("t5_abort_count", got.size(), 6);
    send(8'h41, 1'b1, 2);
    chk("t5_count", got.size(), 7);
    chk("t5_byte", 32'(got[6]), 32'h41);
    chk("t5_hold", 32'(dados_ascii), 32'h41);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
